onchip_mem_pipelined: RTL

Parametrised Avalon-MM single-port on-chip RAM slave, generalising the fixed 32-bit/6049-word system memory. Adds configurable width, depth and read latency, plus readdatavalid/waitrequest pipelined handshaking. Optionally zero-fills the array after reset under a small state machine. It sits on the Nios II data/instruction interconnect as the main on-chip memory.

---
 rtl/onchip_mem_pipelined.sv | 128 ++++++++++++
 1 files changed

// File: rtl/onchip_mem_pipelined.sv
// Single-port Avalon-MM on-chip RAM slave with a pipelined read path
// (readdatavalid/waitrequest) and an optional zero-fill pass after reset.
//
// state   | meaning
// S_CLEAR | zero-filling word clear_cnt, slave busy
// S_READY | array usable, commands accepted while clken=1
module onchip_mem_pipelined #(
  parameter int    DATA_W         = 32,
  parameter int    ADDR_W         = 13,
  parameter int    DEPTH          = 6049,
  parameter int    READ_LATENCY   = 1,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {S_CLEAR, S_READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clear_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              cmd_acc;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_word;

  logic              v1;
  logic [DATA_W-1:0] d1;
  logic              v_last;
  logic [DATA_W-1:0] d_last;

  assign in_range    = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
  assign idx         = address[IDX_W-1:0];
  assign waitrequest = ~init_done | ~clken;
  assign cmd_acc     = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = cmd_acc & write & in_range;
  // a combined read+write is a write only, so it never enters the read pipe
  assign rd_acc      = cmd_acc & read & ~write;
  assign rd_word     = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clear_cnt <= '0;
      init_done <= 1'b0;
    end else if (clken) begin
      case (state)
        S_CLEAR: begin
          if (clear_cnt == LAST_IDX) begin
            state     <= S_READY;
            init_done <= 1'b1;
            clear_cnt <= '0;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
        S_READY: init_done <= 1'b1;
        default: state <= S_READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (clken && state == S_CLEAR) begin
        mem[clear_cnt] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < BYTES; i++) begin
          if (byteenable[i]) mem[idx][i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end
    end
  end

  // data registers only load on a valid beat so readdata holds between responses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (clken) begin
      v1 <= rd_acc;
      if (rd_acc) d1 <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (clken) begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end
    assign v_last = v2;
    assign d_last = d2;
  end else begin : g_lat1
    assign v_last = v1;
    assign d_last = d1;
  end

  assign readdatavalid = v_last & clken;
  assign readdata      = d_last;

endmodule
